// File: rtl/chip8_video.sv
// CHIP-8 64x32 monochrome frame buffer with a registered pixel read port,
// a row-per-cycle clear engine and an XOR sprite draw engine with collision.
module chip8_video (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [5:0] chip8_x_in,
    input  logic [4:0] chip8_y_in,
    output logic       chip8_pixel_out,
    input  logic       clear_in,
    input  logic       draw_start_in,
    input  logic [5:0] draw_x_in,
    input  logic [4:0] draw_y_in,
    input  logic [3:0] draw_n_in,
    output logic       sprite_req_out,
    output logic [3:0] sprite_row_out,
    input  logic       sprite_valid_in,
    input  logic [7:0] sprite_byte_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       collision_out
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] frame [32];
    logic [4:0]  clr_row;
    logic [5:0]  org_x;
    logic [4:0]  org_y;
    logic [3:0]  rows_n;
    logic [3:0]  row_idx;
    logic [7:0]  sprite_q;

    logic [6:0]  wr_row7;
    logic [4:0]  wr_row;
    logic [6:0]  col7;
    logic [63:0] wr_mask;
    logic        wr_hit;
    logic [4:0]  next_idx;
    logic [6:0]  next_row7;

    // Row/column sums are 7 bits wide so anything past the edge is clipped, not wrapped.
    always_comb begin
        wr_row7   = {2'b00, org_y} + {3'b000, row_idx};
        wr_row    = wr_row7[4:0];
        col7      = '0;
        wr_mask   = '0;
        for (int unsigned c = 0; c < 8; c++) begin
            col7 = {1'b0, org_x} + 7'(c);
            if (col7 < 7'd64 && sprite_q[3'(7 - c)]) begin
                wr_mask[col7[5:0]] = 1'b1;
            end
        end
        wr_hit    = |(frame[wr_row] & wr_mask);
        next_idx  = {1'b0, row_idx} + 5'd1;
        next_row7 = {2'b00, org_y} + {2'b00, next_idx};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_in) begin
                    state_next = CLEAR;
                end else if (draw_start_in) begin
                    state_next = (draw_n_in == 4'd0) ? DONE : FETCH;
                end
            end
            CLEAR: begin
                if (clr_row == 5'd31) begin
                    state_next = DONE;
                end
            end
            FETCH: begin
                if (sprite_valid_in) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (next_idx < {1'b0, rows_n} && next_row7 <= 7'd31) begin
                    state_next = FETCH;
                end else begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sprite_req_out = (state == FETCH);
    assign sprite_row_out = row_idx;
    assign busy_out       = (state != IDLE);
    assign done_out       = (state == DONE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned r = 0; r < 32; r++) begin
                frame[r] <= '0;
            end
            chip8_pixel_out <= 1'b0;
            clr_row         <= '0;
            org_x           <= '0;
            org_y           <= '0;
            rows_n          <= '0;
            row_idx         <= '0;
            sprite_q        <= '0;
            collision_out   <= 1'b0;
        end else begin
            chip8_pixel_out <= frame[chip8_y_in][chip8_x_in];
            case (state)
                IDLE: begin
                    if (clear_in) begin
                        clr_row <= '0;
                    end else if (draw_start_in) begin
                        org_x         <= draw_x_in;
                        org_y         <= draw_y_in;
                        rows_n        <= draw_n_in;
                        row_idx       <= '0;
                        collision_out <= 1'b0;
                    end
                end
                CLEAR: begin
                    frame[clr_row] <= '0;
                    clr_row        <= clr_row + 5'd1;
                end
                FETCH: begin
                    if (sprite_valid_in) begin
                        sprite_q <= sprite_byte_in;
                    end
                end
                WRITE: begin
                    frame[wr_row] <= frame[wr_row] ^ wr_mask;
                    if (wr_hit) begin
                        collision_out <= 1'b1;
                    end
                    row_idx <= next_idx[3:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_video.sv
// Directed self-checking bench for chip8_video: reset, draw, XOR collision,
// edge clipping, fetch wait states, clear priority and reset during clear.
module tb_chip8_video;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [5:0] chip8_x_in;
    logic [4:0] chip8_y_in;
    logic       chip8_pixel_out;
    logic       clear_in;
    logic       draw_start_in;
    logic [5:0] draw_x_in;
    logic [4:0] draw_y_in;
    logic [3:0] draw_n_in;
    logic       sprite_req_out;
    logic [3:0] sprite_row_out;
    logic       sprite_valid_in;
    logic [7:0] sprite_byte_in;
    logic       busy_out;
    logic       done_out;
    logic       collision_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] sprite_mem [16];

    int         busy_cnt;
    int         done_cnt;
    int         fetch_cnt;
    logic [3:0] fetch_rows [16];
    int         waited;
    logic       hold_ok;

    chip8_video dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .chip8_x_in      (chip8_x_in),
        .chip8_y_in      (chip8_y_in),
        .chip8_pixel_out (chip8_pixel_out),
        .clear_in        (clear_in),
        .draw_start_in   (draw_start_in),
        .draw_x_in       (draw_x_in),
        .draw_y_in       (draw_y_in),
        .draw_n_in       (draw_n_in),
        .sprite_req_out  (sprite_req_out),
        .sprite_row_out  (sprite_row_out),
        .sprite_valid_in (sprite_valid_in),
        .sprite_byte_in  (sprite_byte_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .collision_out   (collision_out)
    );

    always #5 clk_in = ~clk_in;

    // Issues one command and plays the sprite memory until the engine goes idle.
    task automatic run_cmd(input logic clr, input logic drw, input logic [5:0] x,
                           input logic [4:0] y, input logic [3:0] n,
                           input logic [3:0] delay_row, input int delay_n);
        logic in_wait;
        busy_cnt  = 0;
        done_cnt  = 0;
        fetch_cnt = 0;
        waited    = 0;
        hold_ok   = 1'b1;
        in_wait   = 1'b0;
        clear_in      = clr;
        draw_start_in = drw;
        draw_x_in     = x;
        draw_y_in     = y;
        draw_n_in     = n;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_in);
            clear_in      = 1'b0;
            draw_start_in = 1'b0;
            if (in_wait && !(sprite_req_out && sprite_row_out == delay_row)) hold_ok = 1'b0;
            if (busy_out) busy_cnt++;
            if (done_out) done_cnt++;
            if (sprite_req_out) begin
                if (sprite_row_out == delay_row && waited < delay_n) begin
                    sprite_valid_in = 1'b0;
                    in_wait = 1'b1;
                    waited++;
                end else begin
                    sprite_valid_in = 1'b1;
                    sprite_byte_in  = sprite_mem[sprite_row_out];
                    in_wait = 1'b0;
                    if (fetch_cnt < 16) fetch_rows[fetch_cnt] = sprite_row_out;
                    fetch_cnt++;
                end
            end else begin
                sprite_valid_in = 1'b0;
                sprite_byte_in  = 8'h00;
            end
            if (!busy_out) break;
        end
    endtask

    task automatic read_pix(input logic [5:0] x, input logic [4:0] y, output logic p);
        chip8_x_in = x;
        chip8_y_in = y;
        @(negedge clk_in);
        p = chip8_pixel_out;
    endtask

    task automatic read_byte(input logic [5:0] x, input logic [4:0] y, output logic [7:0] b);
        logic p;
        for (int c = 0; c < 8; c++) begin
            read_pix(x + 6'(c), y, p);
            b[7-c] = p;
        end
    endtask

    task automatic test_reset();
        logic p;
        int   nz;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        total++;
        if ({chip8_pixel_out, sprite_req_out, sprite_row_out, busy_out, done_out, collision_out} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {chip8_pixel_out, sprite_req_out, sprite_row_out, busy_out, done_out, collision_out});
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        nz = 0;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 64; x++) begin
                read_pix(6'(x), 5'(y), p);
                if (p !== 1'b0) nz++;
            end
        end
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL reset_frame nonzero_pixels=%0d want=0", nz);
        end
    endtask

    task automatic test_draw_basic();
        logic [7:0] b;
        sprite_mem[0] = 8'hF0;
        run_cmd(1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 4'd15, 0);
        total++; if (busy_cnt !== 3) begin bad++; $display("FAIL draw_busy got=%0d want=3", busy_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL draw_done got=%0d want=1", done_cnt); end
        total++; if (collision_out !== 1'b0) begin bad++; $display("FAIL draw_coll got=%b want=0", collision_out); end
        read_byte(6'd0, 5'd0, b);
        total++; if (b !== 8'hF0) begin bad++; $display("FAIL draw_pixels got=%h want=f0", b); end
    endtask

    task automatic test_xor_collision();
        logic [7:0] b;
        run_cmd(1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 4'd15, 0);
        read_byte(6'd0, 5'd0, b);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL xor_pixels got=%h want=00", b); end
        total++; if (collision_out !== 1'b1) begin bad++; $display("FAIL xor_coll got=%b want=1", collision_out); end
    endtask

    task automatic test_clip();
        logic p;
        for (int i = 0; i < 16; i++) sprite_mem[i] = 8'hFF;
        run_cmd(1'b0, 1'b1, 6'd60, 5'd30, 4'd4, 4'd15, 0);
        total++; if (fetch_cnt !== 2) begin bad++; $display("FAIL clip_fetches got=%0d want=2", fetch_cnt); end
        total++; if (fetch_rows[0] !== 4'd0 || fetch_rows[1] !== 4'd1) begin
            bad++; $display("FAIL clip_rows got=%0d,%0d want=0,1", fetch_rows[0], fetch_rows[1]);
        end
        total++; if (busy_cnt !== 5) begin bad++; $display("FAIL clip_busy got=%0d want=5", busy_cnt); end
        total++; if (collision_out !== 1'b0) begin bad++; $display("FAIL clip_coll got=%b want=0", collision_out); end
        read_pix(6'd60, 5'd30, p); total++; if (p !== 1'b1) begin bad++; $display("FAIL clip_60_30 got=%b want=1", p); end
        read_pix(6'd63, 5'd31, p); total++; if (p !== 1'b1) begin bad++; $display("FAIL clip_63_31 got=%b want=1", p); end
        read_pix(6'd59, 5'd30, p); total++; if (p !== 1'b0) begin bad++; $display("FAIL clip_59_30 got=%b want=0", p); end
        read_pix(6'd0,  5'd30, p); total++; if (p !== 1'b0) begin bad++; $display("FAIL clip_wrap_col got=%b want=0", p); end
        read_pix(6'd60, 5'd0,  p); total++; if (p !== 1'b0) begin bad++; $display("FAIL clip_wrap_row got=%b want=0", p); end
        read_pix(6'd0,  5'd31, p); total++; if (p !== 1'b0) begin bad++; $display("FAIL clip_0_31 got=%b want=0", p); end
    endtask

    task automatic test_wait_states();
        logic [7:0] b;
        sprite_mem[0] = 8'hA5;
        sprite_mem[1] = 8'h3C;
        run_cmd(1'b0, 1'b1, 6'd20, 5'd10, 4'd2, 4'd1, 5);
        total++; if (waited !== 5) begin bad++; $display("FAIL wait_cycles got=%0d want=5", waited); end
        total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL wait_hold got=%b want=1", hold_ok); end
        total++; if (busy_cnt !== 10) begin bad++; $display("FAIL wait_busy got=%0d want=10", busy_cnt); end
        read_byte(6'd20, 5'd10, b); total++; if (b !== 8'hA5) begin bad++; $display("FAIL wait_row0 got=%h want=a5", b); end
        read_byte(6'd20, 5'd11, b); total++; if (b !== 8'h3C) begin bad++; $display("FAIL wait_row1 got=%h want=3c", b); end
        run_cmd(1'b0, 1'b1, 6'd40, 5'd10, 4'd2, 4'd15, 0);
        total++; if (busy_cnt !== 5) begin bad++; $display("FAIL nowait_busy got=%0d want=5", busy_cnt); end
        read_byte(6'd40, 5'd10, b); total++; if (b !== 8'hA5) begin bad++; $display("FAIL nowait_row0 got=%h want=a5", b); end
        read_byte(6'd40, 5'd11, b); total++; if (b !== 8'h3C) begin bad++; $display("FAIL nowait_row1 got=%h want=3c", b); end
    endtask

    task automatic test_clear_priority();
        logic [7:0] b;
        logic       p;
        run_cmd(1'b0, 1'b1, 6'd20, 5'd10, 4'd1, 4'd15, 0);
        total++; if (collision_out !== 1'b1) begin bad++; $display("FAIL pre_clear_coll got=%b want=1", collision_out); end
        run_cmd(1'b1, 1'b1, 6'd0, 5'd0, 4'd1, 4'd15, 0);
        total++; if (busy_cnt !== 33) begin bad++; $display("FAIL clear_busy got=%0d want=33", busy_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL clear_done got=%0d want=1", done_cnt); end
        total++; if (fetch_cnt !== 0) begin bad++; $display("FAIL clear_fetch got=%0d want=0", fetch_cnt); end
        total++; if (collision_out !== 1'b1) begin bad++; $display("FAIL clear_coll got=%b want=1", collision_out); end
        read_byte(6'd40, 5'd11, b); total++; if (b !== 8'h00) begin bad++; $display("FAIL clear_row11 got=%h want=00", b); end
        read_byte(6'd0, 5'd0, b);   total++; if (b !== 8'h00) begin bad++; $display("FAIL clear_row0 got=%h want=00", b); end
        read_pix(6'd63, 5'd31, p);  total++; if (p !== 1'b0) begin bad++; $display("FAIL clear_63_31 got=%b want=0", p); end
    endtask

    task automatic test_zero_height();
        run_cmd(1'b0, 1'b1, 6'd5, 5'd5, 4'd0, 4'd15, 0);
        total++; if (busy_cnt !== 1) begin bad++; $display("FAIL n0_busy got=%0d want=1", busy_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL n0_done got=%0d want=1", done_cnt); end
        total++; if (fetch_cnt !== 0) begin bad++; $display("FAIL n0_fetch got=%0d want=0", fetch_cnt); end
        total++; if (collision_out !== 1'b0) begin bad++; $display("FAIL n0_coll got=%b want=0", collision_out); end
    endtask

    task automatic test_reset_mid_clear();
        logic p;
        int   dn;
        sprite_mem[0] = 8'hF0;
        run_cmd(1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 4'd15, 0);
        dn = 0;
        clear_in = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (done_out) dn++;
            @(negedge clk_in);
        end
        rst_in = 1'b0;
        #1;
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_abort_busy got=%b want=0", busy_out); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            if (done_out) dn++;
        end
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            if (done_out) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL rst_abort_done got=%0d want=0", dn); end
        read_pix(6'd0, 5'd0, p);
        total++; if (p !== 1'b0) begin bad++; $display("FAIL rst_abort_pixel got=%b want=0", p); end
    endtask

    initial begin
        rst_in          = 1'b0;
        chip8_x_in      = '0;
        chip8_y_in      = '0;
        clear_in        = 1'b0;
        draw_start_in   = 1'b0;
        draw_x_in       = '0;
        draw_y_in       = '0;
        draw_n_in       = '0;
        sprite_valid_in = 1'b0;
        sprite_byte_in  = '0;
        for (int i = 0; i < 16; i++) sprite_mem[i] = 8'h00;
        @(negedge clk_in);
        test_reset();
        test_draw_basic();
        test_xor_collision();
        test_clip();
        test_wait_states();
        test_clear_priority();
        test_zero_height();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
